// File: rtl/inst_loader.sv
// Instruction-memory debug loader: assembles big-endian words from
// UART bytes and writes them sequentially until halt or memory full.
module inst_loader #(
   parameter int                    len_data  = 32,
   parameter int                    len_addr  = 7,
   parameter logic [len_data-1:0]   halt_word = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_start,
   input  logic [7:0]            in_rx_data,
   input  logic                  in_rx_done,
   output logic                  out_debug_flag,
   output logic [len_addr-1:0]   out_addr_debug,
   output logic [len_data-1:0]   out_ins_to_mem,
   output logic                  out_wea_ram_inst,
   output logic [len_addr:0]     out_word_count,
   output logic                  out_load_done,
   output logic                  out_error
);

   localparam int N  = len_data / 8;
   localparam int CW = $clog2(N + 1);

   localparam logic [CW-1:0]       LAST     = CW'(N - 1);
   localparam logic [len_addr-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   state_t              state;
   logic [CW-1:0]       byte_cnt;
   logic [len_data-1:0] shift;
   logic [len_data-1:0] shift_nx;

   // First byte of a word ends up in the MSB after N shifts.
   assign shift_nx = {shift[len_data-9:0], in_rx_data};

   // Load sequencer; every output is registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         byte_cnt         <= '0;
         shift            <= '0;
         out_debug_flag   <= 1'b0;
         out_addr_debug   <= '0;
         out_ins_to_mem   <= '0;
         out_wea_ram_inst <= 1'b0;
         out_word_count   <= '0;
         out_load_done    <= 1'b0;
         out_error        <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (in_start) begin
                  state          <= RECV;
                  byte_cnt       <= '0;
                  shift          <= '0;
                  out_debug_flag <= 1'b1;
                  out_addr_debug <= '0;
                  out_word_count <= '0;
                  out_load_done  <= 1'b0;
                  out_error      <= 1'b0;
               end
            end
            RECV: begin
               if (in_rx_done) begin
                  shift <= shift_nx;
                  if (byte_cnt == LAST) begin
                     out_ins_to_mem   <= shift_nx;
                     out_wea_ram_inst <= 1'b1;
                     byte_cnt         <= '0;
                     state            <= WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               out_wea_ram_inst <= 1'b0;
               out_word_count   <= out_word_count + 1'b1;
               // A strobe here is the first byte of the next word.
               if (in_rx_done) begin
                  shift    <= shift_nx;
                  byte_cnt <= CW'(1);
               end
               if (out_ins_to_mem == halt_word) begin
                  state          <= DONE;
                  out_debug_flag <= 1'b0;
                  out_load_done  <= 1'b1;
               end else if (out_addr_debug == ADDR_MAX) begin
                  state          <= DONE;
                  out_debug_flag <= 1'b0;
                  out_load_done  <= 1'b1;
                  out_error      <= 1'b1;
               end else begin
                  out_addr_debug <= out_addr_debug + 1'b1;
                  state          <= RECV;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: two instances (7-bit and 2-bit
// address) fed the same byte stream, checked against a word-level model.
module tb_inst_loader;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic [7:0] rx_data;
   logic rx_done;

   logic        d0_flag, d0_wea, d0_done, d0_err;
   logic [6:0]  d0_addr;
   logic [31:0] d0_ins;
   logic [7:0]  d0_cnt;

   logic        d1_flag, d1_wea, d1_done, d1_err;
   logic [1:0]  d1_addr;
   logic [31:0] d1_ins;
   logic [2:0]  d1_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   inst_loader #(.len_data(32), .len_addr(7)) u_d0 (
      .clk(clk), .reset(reset), .in_start(start),
      .in_rx_data(rx_data), .in_rx_done(rx_done),
      .out_debug_flag(d0_flag), .out_addr_debug(d0_addr),
      .out_ins_to_mem(d0_ins), .out_wea_ram_inst(d0_wea),
      .out_word_count(d0_cnt), .out_load_done(d0_done),
      .out_error(d0_err)
   );

   inst_loader #(.len_data(32), .len_addr(2)) u_d1 (
      .clk(clk), .reset(reset), .in_start(start),
      .in_rx_data(rx_data), .in_rx_done(rx_done),
      .out_debug_flag(d1_flag), .out_addr_debug(d1_addr),
      .out_ins_to_mem(d1_ins), .out_wea_ram_inst(d1_wea),
      .out_word_count(d1_cnt), .out_load_done(d1_done),
      .out_error(d1_err)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Word-level reference model, one slot per instance.
   int          m_addr[2];
   int          m_cnt[2];
   int          m_nb[2];
   int          m_max[2] = '{127, 3};
   logic [31:0] m_acc[2];
   logic [31:0] m_last[2];
   bit          m_load[2];
   bit          m_stop[2];
   bit          m_err[2];
   logic [38:0] q0[$];
   logic [38:0] q1[$];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_addr[d] = 0; m_cnt[d] = 0; m_nb[d] = 0;
         m_acc[d] = 0; m_last[d] = 0;
         m_load[d] = 0; m_stop[d] = 0; m_err[d] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_start();
      for (int d = 0; d < 2; d++) begin
         if (!m_load[d] || m_stop[d]) begin
            m_addr[d] = 0; m_cnt[d] = 0; m_nb[d] = 0;
            m_acc[d] = 0; m_load[d] = 1; m_stop[d] = 0;
            m_err[d] = 0;
         end
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [38:0] e;
      for (int d = 0; d < 2; d++) begin
         if (m_load[d] && !m_stop[d]) begin
            m_acc[d] = (m_acc[d] << 8) | {24'd0, b};
            m_nb[d]++;
            if (m_nb[d] == 4) begin
               m_nb[d] = 0;
               e = {7'(m_addr[d]), m_acc[d]};
               if (d == 0) q0.push_back(e);
               else q1.push_back(e);
               m_last[d] = m_acc[d];
               m_cnt[d]++;
               if (m_acc[d] == 32'hFFFF_FFFF) begin
                  m_stop[d] = 1;
               end else if (m_addr[d] == m_max[d]) begin
                  m_stop[d] = 1;
                  m_err[d] = 1;
               end else begin
                  m_addr[d]++;
               end
            end
         end
      end
   endtask

   // Every write pulse must match the next expected write.
   always @(negedge clk) begin
      logic [38:0] e;
      if (d0_wea) begin
         chk("wr_flag0", 64'(d0_flag), 64'd1);
         if (q0.size() == 0) begin
            chk("unexp_wr0", 64'd1, 64'd0);
         end else begin
            e = q0.pop_front();
            chk("wr_addr0", 64'(d0_addr), 64'(e[38:32]));
            chk("wr_data0", 64'(d0_ins), 64'(e[31:0]));
         end
      end
      if (d1_wea) begin
         chk("wr_flag1", 64'(d1_flag), 64'd1);
         if (q1.size() == 0) begin
            chk("unexp_wr1", 64'd1, 64'd0);
         end else begin
            e = q1.pop_front();
            chk("wr_addr1", 64'(d1_addr), 64'(e[38:32]));
            chk("wr_data1", 64'(d1_ins), 64'(e[31:0]));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_done = 1'b1;
      model_byte(b);
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      idle(gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++)
         send_byte(w[31-8*i -: 8], $urandom_range(0, maxgap));
   endtask

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      return w;
   endfunction

   task automatic start_load();
      @(posedge clk);
      #1;
      start = 1'b1;
      model_start();
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("st_done0", 64'(d0_done), 64'(m_load[0] && m_stop[0]));
      chk("st_flag0", 64'(d0_flag), 64'(m_load[0] && !m_stop[0]));
      chk("st_done1", 64'(d1_done), 64'(m_load[1] && m_stop[1]));
      chk("st_flag1", 64'(d1_flag), 64'(m_load[1] && !m_stop[1]));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_z0"}, {d0_flag, d0_wea, d0_done, d0_err, d0_addr,
                         d0_cnt, d0_ins}, 64'd0);
      chk({tag, "_z1"}, {d1_flag, d1_wea, d1_done, d1_err, d1_addr,
                         d1_cnt, d1_ins}, 64'd0);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_flag0"}, 64'(d0_flag), 64'(m_load[0] && !m_stop[0]));
      chk({tag, "_done0"}, 64'(d0_done), 64'(m_load[0] && m_stop[0]));
      chk({tag, "_err0"},  64'(d0_err),  64'(m_err[0]));
      chk({tag, "_cnt0"},  64'(d0_cnt),  64'(m_cnt[0]));
      chk({tag, "_addr0"}, 64'(d0_addr), 64'(m_addr[0]));
      chk({tag, "_data0"}, 64'(d0_ins),  64'(m_last[0]));
      chk({tag, "_q0"},    64'(q0.size()), 64'd0);
      chk({tag, "_flag1"}, 64'(d1_flag), 64'(m_load[1] && !m_stop[1]));
      chk({tag, "_done1"}, 64'(d1_done), 64'(m_load[1] && m_stop[1]));
      chk({tag, "_err1"},  64'(d1_err),  64'(m_err[1]));
      chk({tag, "_cnt1"},  64'(d1_cnt),  64'(m_cnt[1]));
      chk({tag, "_addr1"}, 64'(d1_addr), 64'(m_addr[1]));
      chk({tag, "_data1"}, 64'(d1_ins),  64'(m_last[1]));
      chk({tag, "_q1"},    64'(q1.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;
      model_reset();
      idle(3);
      check_zero("rst");
      reset = 1'b1;
      idle(2);

      // Strobes in IDLE are ignored.
      send_byte(8'hAB, 0);
      idle(2);
      check_zero("idle");

      // Single word, known value.
      start_load();
      send_word(32'h2001_0005, 2);
      idle(3);
      chk("t1_data", 64'(d0_ins), 64'h2001_0005);
      check_state("t1");

      // Two more words then halt.
      send_word(rnd_word(), 2);
      send_word(rnd_word(), 0);
      send_word(32'hFFFF_FFFF, 1);
      idle(3);
      chk("t2_cnt", 64'(d0_cnt), 64'd4);
      check_state("t2");

      // Bytes in DONE must not write.
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
      idle(2);
      check_state("t3");

      // Restart; back-to-back words, small memory overflows.
      start_load();
      send_word(32'h1122_3344, 0);
      send_word(32'h5566_7788, 0);
      send_word(rnd_word(), 1);
      send_word(rnd_word(), 2);
      send_word(rnd_word(), 0);
      idle(3);
      chk("t4_err1", 64'(d1_err), 64'd1);
      check_state("t4");
      send_word(32'hFFFF_FFFF, 0);
      idle(3);
      check_state("t5");

      // Reset in the middle of a word.
      start_load();
      send_word(rnd_word(), 1);
      send_byte(8'($urandom), 0);
      send_byte(8'($urandom), 1);
      #3;
      reset = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      idle(2);
      reset = 1'b1;
      start_load();
      send_word(32'hCAFE_0001, 1);
      idle(3);
      check_state("t6");
      send_word(32'hFFFF_FFFF, 1);
      idle(3);
      check_state("t7");

      // Random programs.
      for (int it = 0; it < 8; it++) begin
         int nw;
         nw = $urandom_range(1, 6);
         start_load();
         for (int w = 0; w < nw; w++) send_word(rnd_word(), 2);
         send_word(32'hFFFF_FFFF, 2);
         idle(3);
         check_state("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory debug port that the fetch stage reads from.
- Receives a byte stream from the UART receiver and assembles big-endian 32-bit MIPS words.
- Writes the words sequentially into instruction memory from address 0, driving the debug address, data, write-enable and debug-select lines.
- Stops after the halt word is written, or when memory is full, and releases the memory back to the PC.

Parameters:
- len_data, 32, instruction width in bits; must be a multiple of 8 (bytes per word N = len_data/8).
- len_addr, 7, instruction memory address width (word addressed).
- halt_word, 32'hFFFF_FFFF, instruction value that ends a load.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_start  in  1  one-cycle pulse; begins a load (accepted in IDLE and DONE).
- in_rx_data  in  8  byte from UART receiver.
- in_rx_done  in  1  one-cycle strobe; in_rx_data is valid this cycle.
- out_debug_flag  out  1  high while the loader owns the memory address mux.
- out_addr_debug  out  len_addr  word address to write.
- out_ins_to_mem  out  len_data  assembled word.
- out_wea_ram_inst  out  1  one-cycle write enable.
- out_word_count  out  len_addr+1  number of words written this load.
- out_load_done  out  1  high in DONE.
- out_error  out  1  memory filled without a halt word.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, byte counter=0, shift register=0.
  - All outputs 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - All outputs 0; in_rx_done is ignored.
  - in_start -> RECV. On entry: out_debug_flag=1, addr=0, word_count=0, error=0.
- RECV:
  - Each in_rx_done shifts in_rx_data into the shift register LSB side: word = {word[len_data-9:0], byte}. The first byte ends up as the MSB.
  - On the N-th byte strobe, the full word is latched into out_ins_to_mem, the byte counter resets, and the next state is WRITE.
  - in_start in RECV is ignored.
- WRITE (exactly one cycle):
  - out_wea_ram_inst=1 with out_addr_debug and out_ins_to_mem stable through that cycle.
  - Next cycle: wea=0 and word_count+1.
  - If the word equals halt_word -> DONE; addr is unchanged.
  - Else if addr is 2^len_addr-1 -> DONE with out_error=1.
  - Else addr+1 and return to RECV.
  - A byte strobe arriving during WRITE is accepted as byte 0 of the next word and is never dropped.
- DONE:
  - out_debug_flag=0, out_load_done=1; addr, data and count hold their final values.
  - Byte strobes are ignored.
  - in_start -> RECV with addr, count, error and shift register cleared, and load_done=0.
- Addresses never wrap: no write ever occurs to address 0 twice in one load.
- out_wea_ram_inst is never high while out_debug_flag=0.
- Reset asserted mid-load (any state): immediate return to IDLE, all outputs 0, partial word discarded.
- Latency: the N-th byte strobe at cycle t produces wea high in cycle t+1.

Test Plan:
- Reset, in_start, bytes 8'h20,8'h01,8'h00,8'h05 -> wea pulse one cycle, addr=0, data=32'h2001_0005, word_count=1, debug_flag stays 1.
- Three words then FF,FF,FF,FF -> writes at addr 0..3, last data 32'hFFFF_FFFF, then load_done=1, debug_flag=0, word_count=4, error=0.
- len_addr=2, five non-halt words -> writes at addr 0..3, DONE with error=1, word_count=4; fifth word's bytes ignored, no write to addr 0 again.
- Byte strobe in the same cycle as wea -> that byte becomes MSB of next word (send 11,22,33,44 back-to-back with next 55 on write cycle -> next word 32'h55xx_xxxx).
- Reset low after 2 bytes of word at addr 1 -> all outputs 0 asynchronously; new in_start reloads from addr 0 with a clean shift register.
- In DONE: bytes ignored, no wea; in_start followed by a new program -> addr restarts at 0, load_done drops within one cycle.
